// File: rtl/melody_sequencer.sv
// Song sequencer feeding the note player from a fixed 32-entry melody ROM; a held live key preempts and freezes it.
// Optional build macro: MELODY_SEQ_LOOP_EN restarts the song at index 0 instead of returning to idle.
module melody_sequencer #(
    parameter int CLK_PER_TICK = 1250000,
    parameter int GAP_TICKS    = 1
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic        iStop,
    input  logic        iKeyValid,
    input  logic [12:0] iKeyFreq,
    output logic [12:0] oFreq,
    output logic        oRing,
    output logic        oBusy,
    output logic [4:0]  oIndex,
    output logic        oDone
);

    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state, nxt_state;
    logic [PW-1:0] presc, nxt_presc;
    logic [7:0]    ticks, nxt_ticks;
    logic [4:0]    nxt_index;
    logic          nxt_done;
    logic          tick, advance, song_last;
    logic [3:0]    cur_dur;
    logic [12:0]   play_freq;

    // Melody ROM: get_dur selects the duration field (zero-extended) instead of the half-period.
    function automatic logic [12:0] rom_field(input logic [4:0] idx, input logic get_dur);
        logic [16:0] e;
        case (idx)
            5'd0:    e = {4'd2, 13'd4778};
            5'd1:    e = {4'd2, 13'd4257};
            5'd2:    e = {4'd1, 13'd0};
            5'd3:    e = {4'd4, 13'd3792};
            default: e = 17'd0;
        endcase
        rom_field = get_dur ? {9'd0, e[16:13]} : e[12:0];
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_index = oIndex;
        nxt_presc = presc;
        nxt_ticks = ticks;
        nxt_done  = 1'b0;
        advance   = 1'b0;
        tick      = (presc == PRESC_LAST);
        cur_dur   = 4'(rom_field(oIndex, 1'b1));
        song_last = (oIndex == 5'd31) || (4'(rom_field(oIndex + 5'd1, 1'b1)) == 4'd0);

        if (iStop) begin
            nxt_state = IDLE;
            nxt_index = '0;
            nxt_presc = '0;
            nxt_ticks = '0;
        end else if (state == IDLE) begin
            if (iStart) begin
                nxt_index = '0;
                nxt_presc = '0;
                nxt_ticks = '0;
                if (4'(rom_field(5'd0, 1'b1)) == 4'd0)
                    nxt_done = 1'b1;
                else
                    nxt_state = PLAY;
            end
        end else if (!iKeyValid) begin
            // A held key freezes prescaler and tick counter so playback resumes exactly.
            nxt_presc = tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (state == PLAY) begin
                    if (ticks[3:0] == 4'(cur_dur - 4'd1)) begin
                        if (GAP_TICKS > 0) begin
                            nxt_state = GAP;
                            nxt_ticks = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        nxt_ticks = ticks + 8'd1;
                    end
                end else begin
                    if (ticks == GAP_LAST)
                        advance = 1'b1;
                    else
                        nxt_ticks = ticks + 8'd1;
                end
            end
            if (advance) begin
                nxt_presc = '0;
                nxt_ticks = '0;
                if (song_last) begin
                    nxt_done  = 1'b1;
                    nxt_index = '0;
`ifdef MELODY_SEQ_LOOP_EN
                    nxt_state = PLAY;
`else
                    nxt_state = IDLE;
`endif
                end else begin
                    nxt_index = oIndex + 5'd1;
                    nxt_state = PLAY;
                end
            end
        end
        play_freq = rom_field(nxt_index, 1'b0);
    end

    // Outputs are built from the next state so they change on the edge that samples the cause.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state  <= IDLE;
            oIndex <= '0;
            presc  <= '0;
            ticks  <= '0;
            oFreq  <= '0;
            oRing  <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            state  <= nxt_state;
            oIndex <= nxt_index;
            presc  <= nxt_presc;
            ticks  <= nxt_ticks;
            oFreq  <= iKeyValid ? iKeyFreq : ((nxt_state == PLAY) ? play_freq : 13'd0);
            oRing  <= iKeyValid || ((nxt_state == PLAY) && (play_freq != 13'd0));
            oBusy  <= (nxt_state != IDLE);
            oDone  <= nxt_done;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a song-timeline model queues expected outputs, a monitor compares each cycle.
module tb_melody_sequencer;
    localparam int CPT = 4;
    localparam int GAPT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic        key_valid;
    logic [12:0] key_freq;
    logic [12:0] freq;
    logic        ring;
    logic        busy;
    logic [4:0]  index;
    logic        done;

    melody_sequencer #(.CLK_PER_TICK(CPT), .GAP_TICKS(GAPT)) dut (
        .iClk(clk), .iReset_n(reset_n), .iStart(start), .iStop(stop),
        .iKeyValid(key_valid), .iKeyFreq(key_freq),
        .oFreq(freq), .oRing(ring), .oBusy(busy), .oIndex(index), .oDone(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] freq;
        logic        ring;
        logic        busy;
        logic [4:0]  index;
        logic        done;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    int t_dur[32];
    int t_frq[32];
    int tl_freq[0:2047];
    bit tl_ring[0:2047];
    int tl_idx[0:2047];
    int song_len;
    bit playing;
    int pos;
    string phase;

    // Flatten the melody table into one expected-output entry per clock cycle of a song.
    task automatic build_timeline();
        for (int e = 0; e < 32; e++) begin
            t_dur[e] = 0;
            t_frq[e] = 0;
        end
        t_dur[0] = 2; t_frq[0] = 4778;
        t_dur[1] = 2; t_frq[1] = 4257;
        t_dur[2] = 1; t_frq[2] = 0;
        t_dur[3] = 4; t_frq[3] = 3792;
        song_len = 0;
        for (int e = 0; e < 32; e++) begin
            if (t_dur[e] == 0) break;
            for (int c = 0; c < t_dur[e] * CPT; c++) begin
                tl_freq[song_len] = t_frq[e];
                tl_ring[song_len] = (t_frq[e] != 0);
                tl_idx[song_len]  = e;
                song_len++;
            end
            for (int c = 0; c < GAPT * CPT; c++) begin
                tl_freq[song_len] = 0;
                tl_ring[song_len] = 1'b0;
                tl_idx[song_len]  = e;
                song_len++;
            end
        end
    endtask

    task automatic step(input bit rn, input bit st, input bit sp, input bit kv, input logic [12:0] kf);
        exp_t e;
        bit   dn;
        dn = 1'b0;
        reset_n = rn; start = st; stop = sp; key_valid = kv; key_freq = kf;
        if (!rn) begin
            playing = 1'b0;
            pos = 0;
            e = '0;
        end else begin
            if (sp) begin
                playing = 1'b0;
                pos = 0;
            end else if (!playing) begin
                if (st) begin
                    playing = 1'b1;
                    pos = 0;
                end
            end else if (!kv) begin
                pos++;
                if (pos == song_len) begin
                    dn = 1'b1;
                    pos = 0;
`ifndef MELODY_SEQ_LOOP_EN
                    playing = 1'b0;
`endif
                end
            end
            e.freq  = kv ? kf : (playing ? 13'(tl_freq[pos]) : 13'd0);
            e.ring  = kv || (playing && tl_ring[pos]);
            e.busy  = playing;
            e.index = playing ? 5'(tl_idx[pos]) : 5'd0;
            e.done  = dn;
        end
        exp_q.push_back(e);
        name_q.push_back(phase);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 13'd0);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {freq, ring, busy, index, done};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL %s @%0t: got freq=%0d ring=%0b busy=%0b index=%0d done=%0b, expected freq=%0d ring=%0b busy=%0b index=%0d done=%0b",
                             nm, $time, got.freq, got.ring, got.busy, got.index, got.done,
                             e.freq, e.ring, e.busy, e.index, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        int          kcnt;
        logic [12:0] kf;
        bit          st, sp, kv, rn;
        build_timeline();
        playing = 1'b0;
        pos = 0;

        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 13'd0);
        phase = "idle";
        idle_cycles(4);

        phase = "full_song";
        step(1'b1, 1'b1, 1'b0, 1'b0, 13'd0);
        idle_cycles(60);

        phase = "reset_mid_note";
        step(1'b1, 1'b1, 1'b0, 1'b0, 13'd0);
        idle_cycles(5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 13'd0);
        idle_cycles(6);

        phase = "abort";
        step(1'b1, 1'b1, 1'b0, 1'b0, 13'd0);
        idle_cycles(9);
        step(1'b1, 1'b0, 1'b1, 1'b0, 13'd0);
        idle_cycles(60);

        phase = "start_stop_idle";
        step(1'b1, 1'b1, 1'b1, 1'b0, 13'd0);
        idle_cycles(5);

        phase = "key_preempt";
        step(1'b1, 1'b1, 1'b0, 1'b0, 13'd0);
        idle_cycles(14);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 13'd1000);
        idle_cycles(50);

        phase = "key_idle";
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 13'd2000);
        idle_cycles(3);

        phase = "start_ignored_busy";
        step(1'b1, 1'b1, 1'b0, 1'b0, 13'd0);
        for (int i = 0; i < 60; i++) step(1'b1, (i % 7) == 3, 1'b0, 1'b0, 13'd0);

        phase = "random";
        kcnt = 0;
        kf = 13'd0;
        for (int i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 199) == 0);
            rn = ($urandom_range(0, 799) != 0);
            if (kcnt == 0 && $urandom_range(0, 79) == 0) begin
                kcnt = $urandom_range(1, 25);
                kf = 13'($urandom);
            end
            kv = (kcnt > 0);
            if (kcnt > 0) kcnt--;
            step(rn, st, sp, kv, kf);
        end
        phase = "drain";
        idle_cycles(60);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
